// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction kinds seen at decode, forward-select
// codes and default pipeline geometry.
package cpu_pkg;

    // Instruction class as presented by the decoder. KIND_RSVD behaves as ALU.
    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LOAD = 2'd1,
        KIND_MDU  = 2'd2,
        KIND_RSVD = 2'd3
    } kind_e;

    // Forward-select code meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // First stage at which load data is available for forwarding.
    localparam int LOAD_READY_STG = 2;

    // Default geometry: EX/MEM/WB tracked, 32 architectural registers.
    localparam int NFWD_DEF   = 3;
    localparam int REG_AW_DEF = 5;

endpackage

// File: rtl/hz_operand_sel.sv
// Per-operand forwarding selector: finds the youngest in-flight producer of
// one source register and either forwards from it or requests a stall.
module hz_operand_sel
    import cpu_pkg::*;
#(
    parameter int NFWD   = NFWD_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int FW     = $clog2(NFWD + 1)
) (
    input  logic [REG_AW-1:0]           src_i,
    input  logic                        src_used_i,
    input  logic [NFWD:1]               ent_vld_i,
    input  logic [NFWD:1][REG_AW-1:0]   ent_dst_i,
    input  logic [NFWD:1]               ent_ld_i,
    output logic [FW-1:0]               fwd_sel_o,
    output logic                        stall_o
);

    logic found;

    // Scan from the youngest stage; the first match decides, older ones are ignored.
    always_comb begin
        fwd_sel_o = FW'(FWD_RF);
        stall_o   = 1'b0;
        found     = 1'b0;
        for (int k = 1; k <= NFWD; k++) begin
            if (!found && src_used_i && ent_vld_i[k] &&
                (src_i != '0) && (ent_dst_i[k] == src_i)) begin
                found = 1'b1;
                if (ent_ld_i[k] && (k < LOAD_READY_STG)) begin
                    stall_o = 1'b1;
                end else begin
                    fwd_sel_o = FW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard/forwarding controller. Keeps a shadow copy of the
// destination registers in flight in EX..WB, picks forwarding sources per
// operand, detects load-use and MUL/DIV hazards and tracks the MUL/DIV unit.
module id_hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int NSRC    = 2,
    parameter int NFWD    = NFWD_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MDU_LAT = 8,
    parameter int FW      = $clog2(NFWD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NSRC*REG_AW-1:0]   id_src,
    input  logic [NSRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]        id_dst,
    input  logic                     id_wr,
    input  logic [1:0]               id_kind,
    input  logic                     pipe_hold,
    input  logic                     flush,
    output logic [NSRC*FW-1:0]       fwd_sel,
    output logic                     stall,
    output logic                     issue,
    output logic                     mdu_busy
);

    localparam int CW = $clog2(MDU_LAT + 1);

    // Shadow pipe, entry k mirrors the instruction in stage k.
    logic [NFWD:1]               vld_q, vld_d;
    logic [NFWD:1][REG_AW-1:0]   dst_q, dst_d;
    logic [NFWD:1]               ld_q,  ld_d;

    // MUL/DIV tracking.
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [REG_AW-1:0]           mdu_dst_q, mdu_dst_d;

    logic [NSRC-1:0]             op_stall;
    logic                        mdu_src_hit;
    logic                        mdu_stall;

    assign mdu_busy = (cnt_q != '0);

    // One selector per source operand.
    for (genvar i = 0; i < NSRC; i++) begin : g_op
        hz_operand_sel #(
            .NFWD   (NFWD),
            .REG_AW (REG_AW),
            .FW     (FW)
        ) u_sel (
            .src_i      (id_src[i*REG_AW +: REG_AW]),
            .src_used_i (id_src_used[i]),
            .ent_vld_i  (vld_q),
            .ent_dst_i  (dst_q),
            .ent_ld_i   (ld_q),
            .fwd_sel_o  (fwd_sel[i*FW +: FW]),
            .stall_o    (op_stall[i])
        );
    end

    // Combine operand stalls with MUL/DIV RAW, structural and WAW hazards.
    always_comb begin
        mdu_src_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (id_src_used[i] && (mdu_dst_q != '0) &&
                (id_src[i*REG_AW +: REG_AW] == mdu_dst_q)) begin
                mdu_src_hit = 1'b1;
            end
        end
        mdu_stall = mdu_busy &&
                    (mdu_src_hit ||
                     (id_kind == KIND_MDU) ||
                     (id_wr && (mdu_dst_q != '0) && (id_dst == mdu_dst_q)));
        stall = id_valid && ((|op_stall) || mdu_stall);
        issue = id_valid && !stall && !pipe_hold && !flush && !rst;
    end

    // Next state: shift the shadow pipe unless frozen; MUL/DIV never becomes
    // a forwarding producer, so it enters as an invalid slot.
    always_comb begin
        vld_d     = vld_q;
        dst_d     = dst_q;
        ld_d      = ld_q;
        cnt_d     = cnt_q;
        mdu_dst_d = mdu_dst_q;
        if (!pipe_hold) begin
            for (int k = NFWD; k >= 2; k--) begin
                vld_d[k] = vld_q[k-1];
                dst_d[k] = dst_q[k-1];
                ld_d[k]  = ld_q[k-1];
            end
            vld_d[1] = issue && (id_kind != KIND_MDU);
            dst_d[1] = (issue && id_wr) ? id_dst : '0;
            ld_d[1]  = issue && (id_kind == KIND_LOAD);
        end
        // The busy counter runs regardless of pipe_hold.
        if (issue && (id_kind == KIND_MDU)) begin
            cnt_d     = CW'(MDU_LAT);
            mdu_dst_d = id_dst;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            dst_q     <= '0;
            ld_q      <= '0;
            cnt_q     <= '0;
            mdu_dst_q <= '0;
        end else begin
            vld_q     <= vld_d;
            dst_q     <= dst_d;
            ld_q      <= ld_d;
            cnt_q     <= cnt_d;
            mdu_dst_q <= mdu_dst_d;
        end
    end

endmodule
